// File: rtl/superh16_pkg.sv
// superh16_pkg: shared types for the age-ordered load queue.
//   lq_ptr_t          queue pointer, index bits plus one wrap bit
//   lq_entry_t        one load queue entry (valid, done, addr, size, rob_idx)
//   size_to_bytemask  8-bit byte-enable mask of a naturally aligned access
// The entry struct is sized from the LQ_* localparams below; a build that
// overrides the queue's DEPTH/VA_W/ROB_W parameters must change these too.
package superh16_pkg;

    localparam int LQ_DEPTH = 32;
    localparam int LQ_PTR_W = $clog2(LQ_DEPTH) + 1;
    localparam int LQ_VA_W  = 48;
    localparam int LQ_ROB_W = 8;

    typedef logic [LQ_PTR_W-1:0] lq_ptr_t;

    typedef struct packed {
        logic                valid;
        logic                done;
        logic [LQ_VA_W-1:0]  addr;
        logic [1:0]          size;
        logic [LQ_ROB_W-1:0] rob_idx;
    } lq_entry_t;

    // Accesses are naturally aligned, so the shifted mask never leaves the dword.
    function automatic logic [7:0] size_to_bytemask(input logic [2:0] offset,
                                                    input logic [1:0] size);
        logic [7:0] base;
        case (size)
            2'd0:    base = 8'h01;
            2'd1:    base = 8'h03;
            2'd2:    base = 8'h0f;
            default: base = 8'hff;
        endcase
        return base << offset;
    endfunction

endpackage

// File: rtl/superh16_lq_age_pick.sv
// superh16_lq_age_pick: oldest-first priority select over the snoop candidate
// vector. The vector is scanned starting at entry index `base` (the store's
// first younger load) and wrapping around, so the first hit is the candidate
// closest in age to the store.
//   cand   in   DEPTH   candidate bit per entry index
//   base   in   IDX_W   index where the scan starts (oldest position)
//   found  out  1       at least one candidate set
//   idx    out  IDX_W   entry index of the oldest candidate
module superh16_lq_age_pick #(
    parameter  int DEPTH = 32,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0] cand,
    input  logic [IDX_W-1:0] base,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] pos;

    // Scanning from the youngest offset down lets the oldest hit win last.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        pos   = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            pos = base + IDX_W'(k);
            if (cand[pos]) begin
                found = 1'b1;
                idx   = pos;
            end
        end
    end

endmodule

// File: rtl/superh16_load_queue_ordered.sv
// superh16_load_queue_ordered: age-ordered circular load queue.
// Loads are allocated in program order at tail, completed by the load units,
// retired from head, and squashed back to a flush pointer. Store addresses
// are snooped against younger completed loads; the oldest overlapping one is
// reported one cycle later as an ordering violation.
//   clk, rst_n                   clock, asynchronous active-low reset
//   alloc_req/alloc_rob_idx      dispatch allocation (contiguous from port 0)
//   alloc_ready/alloc_ptr        room for NUM_ALLOC loads / granted pointers
//   exec_valid/ptr/addr/size     load completion from the load units
//   st_valid/addr/size/lq_ptr    store address snoop
//   viol_valid/viol_rob_idx      registered ordering violation pulse
//   commit_cnt                   loads retiring from head this cycle
//   flush_valid/flush_ptr        squash from flush_ptr to tail
//   count/empty                  occupancy
// Optional: define LQ_PERF_CNT_EN to add saturating counters perf_full_stall
// (cycles with a request blocked by !alloc_ready) and perf_viol (violations).
module superh16_load_queue_ordered
    import superh16_pkg::*;
#(
    parameter  int DEPTH     = LQ_DEPTH,
    parameter  int NUM_ALLOC = 4,
    parameter  int NUM_EXEC  = 2,
    parameter  int RETIRE_W  = 4,
    parameter  int VA_W      = LQ_VA_W,
    parameter  int ROB_W     = LQ_ROB_W,
    localparam int PTR_W     = $clog2(DEPTH) + 1,
    localparam int CNT_W     = $clog2(RETIRE_W + 1)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_ALLOC-1:0]       alloc_req,
    input  logic [NUM_ALLOC*ROB_W-1:0] alloc_rob_idx,
    output logic                       alloc_ready,
    output logic [NUM_ALLOC*PTR_W-1:0] alloc_ptr,
    input  logic [NUM_EXEC-1:0]        exec_valid,
    input  logic [NUM_EXEC*PTR_W-1:0]  exec_ptr,
    input  logic [NUM_EXEC*VA_W-1:0]   exec_addr,
    input  logic [NUM_EXEC*2-1:0]      exec_size,
    input  logic                       st_valid,
    input  logic [VA_W-1:0]            st_addr,
    input  logic [1:0]                 st_size,
    input  logic [PTR_W-1:0]           st_lq_ptr,
    output logic                       viol_valid,
    output logic [ROB_W-1:0]           viol_rob_idx,
    input  logic [CNT_W-1:0]           commit_cnt,
    input  logic                       flush_valid,
    input  logic [PTR_W-1:0]           flush_ptr,
    output logic [PTR_W-1:0]           count,
    output logic                       empty
`ifdef LQ_PERF_CNT_EN
    ,
    output logic [31:0]                perf_full_stall,
    output logic [31:0]                perf_viol
`endif
);

    localparam int IDX_W = PTR_W - 1;

    lq_entry_t        ent [DEPTH];
    lq_ptr_t          head;
    lq_ptr_t          tail;
    logic [PTR_W-1:0] n_alloc;
    logic [PTR_W-1:0] n_commit;
    logic [PTR_W-1:0] flush_len;
    logic [PTR_W-1:0] st_rel;
    logic [7:0]       st_mask;
    logic             alloc_fire;
    logic [DEPTH-1:0] kill;
    logic [DEPTH-1:0] cand;
    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;

    assign count       = tail - head;
    assign empty       = (count == '0);
    assign alloc_ready = (PTR_W'(DEPTH) - count) >= PTR_W'(NUM_ALLOC);
    assign alloc_fire  = alloc_ready && !flush_valid;
    assign flush_len   = tail - flush_ptr;

    always_comb begin
        alloc_ptr = '0;
        for (int k = 0; k < NUM_ALLOC; k++)
            alloc_ptr[k*PTR_W +: PTR_W] = tail + PTR_W'(k);
    end

    always_comb begin
        n_alloc = '0;
        for (int k = 0; k < NUM_ALLOC; k++)
            n_alloc = n_alloc + PTR_W'(alloc_req[k]);
    end

    // Over-commit is clamped so head never passes tail.
    always_comb begin
        n_commit = (PTR_W'(commit_cnt) > count) ? count : PTR_W'(commit_cnt);
    end

    // Per-entry retire/flush kill and snoop candidate. Distances are taken
    // modulo DEPTH from head (or flush_ptr); every valid entry lies within
    // count of head, so the index distance equals its pointer distance.
    always_comb begin
        logic [IDX_W-1:0] rel_head;
        logic [IDX_W-1:0] rel_flush;
        rel_head  = '0;
        rel_flush = '0;
        st_mask   = size_to_bytemask(st_addr[2:0], st_size);
        st_rel    = st_lq_ptr - head;
        kill      = '0;
        cand      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            rel_head  = IDX_W'(i) - head[IDX_W-1:0];
            rel_flush = IDX_W'(i) - flush_ptr[IDX_W-1:0];
            kill[i] = ({1'b0, rel_head} < n_commit) ||
                      (flush_valid && ({1'b0, rel_flush} < flush_len));
            cand[i] = ent[i].valid && ent[i].done &&
                      ({1'b0, rel_head} >= st_rel) &&
                      (ent[i].addr[VA_W-1:3] == st_addr[VA_W-1:3]) &&
                      (|(size_to_bytemask(ent[i].addr[2:0], ent[i].size) & st_mask));
        end
    end

    superh16_lq_age_pick #(.DEPTH(DEPTH)) u_age_pick (
        .cand  (cand),
        .base  (st_lq_ptr[IDX_W-1:0]),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Later assignments win: a kill overrides an exec to the same entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                ent[i] <= '0;
        end else begin
            for (int e = 0; e < NUM_EXEC; e++) begin
                if (exec_valid[e] && ent[exec_ptr[e*PTR_W +: IDX_W]].valid) begin
                    ent[exec_ptr[e*PTR_W +: IDX_W]].done <= 1'b1;
                    ent[exec_ptr[e*PTR_W +: IDX_W]].addr <= exec_addr[e*VA_W +: VA_W];
                    ent[exec_ptr[e*PTR_W +: IDX_W]].size <= exec_size[e*2 +: 2];
                end
            end
            if (alloc_fire) begin
                for (int k = 0; k < NUM_ALLOC; k++) begin
                    if (alloc_req[k]) begin
                        ent[tail[IDX_W-1:0] + IDX_W'(k)] <= '{valid:   1'b1,
                                                             done:    1'b0,
                                                             addr:    '0,
                                                             size:    '0,
                                                             rob_idx: alloc_rob_idx[k*ROB_W +: ROB_W]};
                    end
                end
            end
            for (int i = 0; i < DEPTH; i++)
                if (kill[i])
                    ent[i] <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
        end else begin
            head <= head + n_commit;
            if (flush_valid)
                tail <= flush_ptr;
            else if (alloc_fire)
                tail <= tail + n_alloc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            viol_valid   <= 1'b0;
            viol_rob_idx <= '0;
        end else begin
            viol_valid <= st_valid && !flush_valid && pick_found;
            if (st_valid && !flush_valid && pick_found)
                viol_rob_idx <= ent[pick_idx].rob_idx;
        end
    end

`ifdef LQ_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_full_stall <= '0;
            perf_viol       <= '0;
        end else begin
            if ((alloc_req != '0) && !alloc_ready && (perf_full_stall != '1))
                perf_full_stall <= perf_full_stall + 32'd1;
            if (viol_valid && (perf_viol != '1))
                perf_viol <= perf_viol + 32'd1;
        end
    end
`endif

    // Interface protocol checks.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            a_alloc_contig: assert ((alloc_req & (alloc_req + NUM_ALLOC'(1))) == '0);
            a_commit_le_count: assert (PTR_W'(commit_cnt) <= count);
            if (flush_valid)
                a_flush_in_range: assert ((flush_ptr - head) <= count);
            for (int e = 0; e < NUM_EXEC; e++)
                if (exec_valid[e])
                    a_exec_valid_entry: assert (ent[exec_ptr[e*PTR_W +: IDX_W]].valid);
        end
    end

endmodule
